// File: rtl/transmitter_block.sv
// Avalon-MM traffic transmitter: issues single read commands or write bursts
// with an incrementing byte pattern, one command at a time.
module transmitter_block #(
    parameter int ADDR_W      = 31,
    parameter int AMM_DATA_W  = 128,
    parameter int AMM_BURST_W = 11
) (
    input  logic                    clk_i,
    input  logic                    rst_i,

    input  logic                    start_test_i,
    input  logic [AMM_BURST_W-2:0]  burstcount_i,
    input  logic [7:0]              data_pattern_i,

    input  logic                    trans_valid_i,
    input  logic [ADDR_W-1:0]       trans_addr_i,
    input  logic                    trans_type_i,
    output logic                    trans_process_o,
    output logic                    trans_busy_o,

    output logic [ADDR_W-1:0]       amm_address_o,
    output logic                    amm_read_o,
    output logic                    amm_write_o,
    output logic [AMM_DATA_W-1:0]   amm_writedata_o,
    output logic [AMM_DATA_W/8-1:0] amm_byteenable_o,
    output logic [AMM_BURST_W-1:0]  amm_burstcount_o,
    input  logic                    amm_waitrequest_i,

    output logic                    cmd_stb_o
);

    localparam int BYTES_W = AMM_DATA_W / 8;
    localparam logic [AMM_BURST_W-1:0] BEAT_ONE = 1;

    typedef enum logic [1:0] {
        IDLE_S,
        WRITE_S,
        READ_S
    } state_t;

    state_t                 state_q;
    logic [AMM_BURST_W-2:0] burst_q;
    logic [7:0]             pattern_q;
    logic [AMM_BURST_W-1:0] beat_q;
    logic [ADDR_W-1:0]      addr_q;
    logic                   read_q;
    logic                   write_q;

    logic [AMM_BURST_W-1:0] last_beat_idx;
    logic                   last_beat;
    logic [7:0]             beat_byte;

    // Burst length and beat payload derived from the latched test setup
    assign last_beat_idx = {1'b0, burst_q};
    assign last_beat     = (beat_q == last_beat_idx);
    assign beat_byte     = pattern_q + 8'(beat_q);

    assign amm_address_o    = addr_q;
    assign amm_read_o       = read_q;
    assign amm_write_o      = write_q;
    assign amm_burstcount_o = last_beat_idx + BEAT_ONE;
    assign amm_writedata_o  = {BYTES_W{beat_byte}};
    assign amm_byteenable_o = '1;

    assign trans_process_o = (state_q != IDLE_S);
    assign trans_busy_o    = trans_process_o | read_q | write_q;

    // The strobe coincides with the cycle the slave takes the command, so it
    // is qualified directly by waitrequest rather than registered.
    assign cmd_stb_o = ~amm_waitrequest_i & (read_q | (write_q & (beat_q == '0)));

    // Command sequencer: accept in IDLE_S, then hold the request until taken
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE_S;
            burst_q   <= '0;
            pattern_q <= '0;
            beat_q    <= '0;
            addr_q    <= '0;
            read_q    <= 1'b0;
            write_q   <= 1'b0;
        end else begin
            if (state_q == IDLE_S && start_test_i) begin
                burst_q   <= burstcount_i;
                pattern_q <= data_pattern_i;
            end

            case (state_q)
                IDLE_S: begin
                    if (trans_valid_i) begin
                        addr_q <= trans_addr_i;
                        beat_q <= '0;
                        if (trans_type_i) begin
                            state_q <= READ_S;
                            read_q  <= 1'b1;
                        end else begin
                            state_q <= WRITE_S;
                            write_q <= 1'b1;
                        end
                    end
                end
                WRITE_S: begin
                    if (!amm_waitrequest_i) begin
                        if (last_beat) begin
                            write_q <= 1'b0;
                            beat_q  <= '0;
                            state_q <= IDLE_S;
                        end else begin
                            beat_q <= beat_q + BEAT_ONE;
                        end
                    end
                end
                READ_S: begin
                    if (!amm_waitrequest_i) begin
                        read_q  <= 1'b0;
                        state_q <= IDLE_S;
                    end
                end
                default: begin
                    state_q <= IDLE_S;
                    read_q  <= 1'b0;
                    write_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_transmitter_block.sv
// Directed self-checking bench for transmitter_block.
module tb_transmitter_block;

    localparam int ADDR_W      = 31;
    localparam int AMM_DATA_W  = 128;
    localparam int AMM_BURST_W = 11;

    logic                    clk_i = 1'b0;
    logic                    rst_i = 1'b1;
    logic                    start_test_i = 1'b0;
    logic [AMM_BURST_W-2:0]  burstcount_i = '0;
    logic [7:0]              data_pattern_i = '0;
    logic                    trans_valid_i = 1'b0;
    logic [ADDR_W-1:0]       trans_addr_i = '0;
    logic                    trans_type_i = 1'b0;
    logic                    trans_process_o;
    logic                    trans_busy_o;
    logic [ADDR_W-1:0]       amm_address_o;
    logic                    amm_read_o;
    logic                    amm_write_o;
    logic [AMM_DATA_W-1:0]   amm_writedata_o;
    logic [AMM_DATA_W/8-1:0] amm_byteenable_o;
    logic [AMM_BURST_W-1:0]  amm_burstcount_o;
    logic                    amm_waitrequest_i = 1'b0;
    logic                    cmd_stb_o;

    int n_checks = 0;
    int n_fail   = 0;

    logic       wr_seq   [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] byte_seq [8] = '{8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h01};

    transmitter_block #(
        .ADDR_W      (ADDR_W),
        .AMM_DATA_W  (AMM_DATA_W),
        .AMM_BURST_W (AMM_BURST_W)
    ) dut (
        .clk_i             (clk_i),
        .rst_i             (rst_i),
        .start_test_i      (start_test_i),
        .burstcount_i      (burstcount_i),
        .data_pattern_i    (data_pattern_i),
        .trans_valid_i     (trans_valid_i),
        .trans_addr_i      (trans_addr_i),
        .trans_type_i      (trans_type_i),
        .trans_process_o   (trans_process_o),
        .trans_busy_o      (trans_busy_o),
        .amm_address_o     (amm_address_o),
        .amm_read_o        (amm_read_o),
        .amm_write_o       (amm_write_o),
        .amm_writedata_o   (amm_writedata_o),
        .amm_byteenable_o  (amm_byteenable_o),
        .amm_burstcount_o  (amm_burstcount_o),
        .amm_waitrequest_i (amm_waitrequest_i),
        .cmd_stb_o         (cmd_stb_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        // Reset values while reset is held
        #3;
        check_val("rst_write",   amm_write_o, 0);
        check_val("rst_read",    amm_read_o, 0);
        check_val("rst_stb",     cmd_stb_o, 0);
        check_val("rst_process", trans_process_o, 0);
        check_val("rst_busy",    trans_busy_o, 0);
        check_val("rst_addr",    amm_address_o, 0);
        check_val("rst_bcount",  amm_burstcount_o, 1);
        check_val("rst_be",      amm_byteenable_o, 16'hFFFF);
        tick(); tick();
        rst_i = 1'b0;

        // Single-beat write
        tick(); start_test_i = 1'b1; burstcount_i = '0; data_pattern_i = 8'h10;
        #1 check_val("t1_idle_process", trans_process_o, 0);
        tick(); start_test_i = 1'b0; trans_valid_i = 1'b1; trans_addr_i = 'h100; trans_type_i = 1'b0;
        #1 check_val("t1_accept_write", amm_write_o, 0);
        tick(); trans_valid_i = 1'b0;
        #1;
        check_val("t1_write",   amm_write_o, 1);
        check_val("t1_process", trans_process_o, 1);
        check_val("t1_busy",    trans_busy_o, 1);
        check_val("t1_bcount",  amm_burstcount_o, 1);
        check_val("t1_wdata",   amm_writedata_o, {16{8'h10}});
        check_val("t1_addr",    amm_address_o, 'h100);
        check_val("t1_stb",     cmd_stb_o, 1);
        tick(); #1;
        check_val("t1_write_end",   amm_write_o, 0);
        check_val("t1_process_end", trans_process_o, 0);
        check_val("t1_stb_end",     cmd_stb_o, 0);

        // 4-beat write with stalls, byte wrap, start_test ignored mid-burst
        tick(); start_test_i = 1'b1; burstcount_i = 10'd3; data_pattern_i = 8'hFE;
        tick(); start_test_i = 1'b0; trans_valid_i = 1'b1; trans_addr_i = 'h200; trans_type_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            trans_valid_i     = 1'b0;
            amm_waitrequest_i = wr_seq[i];
            start_test_i      = (i == 1);
            burstcount_i      = (i == 1) ? 10'd7 : 10'd3;
            #1;
            check_val($sformatf("t2_write_%0d", i),  amm_write_o, 1);
            check_val($sformatf("t2_wdata_%0d", i),  amm_writedata_o, {16{byte_seq[i]}});
            check_val($sformatf("t2_bcount_%0d", i), amm_burstcount_o, 4);
            check_val($sformatf("t2_stb_%0d", i),    cmd_stb_o, (i == 0));
            check_val($sformatf("t2_read_%0d", i),   amm_read_o, 0);
        end
        tick(); amm_waitrequest_i = 1'b0; start_test_i = 1'b0;
        #1;
        check_val("t2_write_end",   amm_write_o, 0);
        check_val("t2_process_end", trans_process_o, 0);

        // Read with 3 stall cycles, using the previously latched burst length
        tick(); trans_valid_i = 1'b1; trans_addr_i = 'h2A; trans_type_i = 1'b1; amm_waitrequest_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            trans_valid_i     = 1'b0;
            trans_addr_i      = 'h0;
            amm_waitrequest_i = (i < 3);
            #1;
            check_val($sformatf("t3_read_%0d", i),   amm_read_o, 1);
            check_val($sformatf("t3_write_%0d", i),  amm_write_o, 0);
            check_val($sformatf("t3_addr_%0d", i),   amm_address_o, 'h2A);
            check_val($sformatf("t3_bcount_%0d", i), amm_burstcount_o, 4);
            check_val($sformatf("t3_stb_%0d", i),    cmd_stb_o, (i == 3));
        end
        tick(); amm_waitrequest_i = 1'b0;
        #1;
        check_val("t3_read_end",    amm_read_o, 0);
        check_val("t3_process_end", trans_process_o, 0);

        // Back-to-back alternating commands with trans_valid_i held
        tick(); start_test_i = 1'b1; burstcount_i = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            start_test_i  = 1'b0;
            trans_valid_i = 1'b1;
            trans_type_i  = ((i / 2) % 2) == 1;
            trans_addr_i  = ADDR_W'(i);
            #1;
            if (i % 2 == 0) begin
                check_val($sformatf("t4_busy_idle_%0d", i), trans_busy_o, 0);
                check_val($sformatf("t4_req_idle_%0d", i),  {amm_read_o, amm_write_o}, 0);
            end else begin
                check_val($sformatf("t4_busy_%0d", i),  trans_busy_o, 1);
                check_val($sformatf("t4_write_%0d", i), amm_write_o, ((i / 2) % 2) == 0);
                check_val($sformatf("t4_read_%0d", i),  amm_read_o, ((i / 2) % 2) == 1);
                check_val($sformatf("t4_stb_%0d", i),   cmd_stb_o, 1);
                check_val($sformatf("t4_addr_%0d", i),  amm_address_o, i - 1);
            end
        end
        tick(); trans_valid_i = 1'b0;
        #1 check_val("t4_busy_end", trans_busy_o, 0);

        // Reset during beat 2 of a 4-beat write
        tick(); start_test_i = 1'b1; burstcount_i = 10'd3; data_pattern_i = 8'h40;
        tick(); start_test_i = 1'b0; trans_valid_i = 1'b1; trans_addr_i = 'h300; trans_type_i = 1'b0;
        tick(); trans_valid_i = 1'b0;
        #1 check_val("t5_beat0", amm_writedata_o, {16{8'h40}});
        tick();
        #1 check_val("t5_beat1", amm_writedata_o, {16{8'h41}});
        tick(); rst_i = 1'b1;
        #1;
        check_val("t5_rst_write",   amm_write_o, 0);
        check_val("t5_rst_read",    amm_read_o, 0);
        check_val("t5_rst_stb",     cmd_stb_o, 0);
        check_val("t5_rst_process", trans_process_o, 0);
        check_val("t5_rst_busy",    trans_busy_o, 0);
        check_val("t5_rst_addr",    amm_address_o, 0);
        check_val("t5_rst_bcount",  amm_burstcount_o, 1);
        check_val("t5_rst_wdata",   amm_writedata_o, 0);
        tick(); tick(); rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            check_val($sformatf("t5_quiet_%0d", i), {amm_read_o, amm_write_o, trans_busy_o}, 0);
        end
        tick(); trans_valid_i = 1'b1; trans_type_i = 1'b1; trans_addr_i = 'h33;
        tick(); trans_valid_i = 1'b0;
        #1;
        check_val("t5_new_read",   amm_read_o, 1);
        check_val("t5_new_addr",   amm_address_o, 'h33);
        check_val("t5_new_bcount", amm_burstcount_o, 1);
        check_val("t5_new_stb",    cmd_stb_o, 1);
        tick(); #1;
        check_val("t5_new_end", amm_read_o, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
